// File: rtl/uxn_pkg.sv
// Shared opcode map, FSM/error enums and per-opcode stack-effect decode for uxn_stack_alu.
// Build option: UXN_MULDIV_EN makes MUL/DIV/MOD legal; otherwise they decode as illegal.
package uxn_pkg;

  localparam int OPC_W = 8;

  localparam logic [OPC_W-1:0] OP_ADD  = 8'h01;
  localparam logic [OPC_W-1:0] OP_SUB  = 8'h02;
  localparam logic [OPC_W-1:0] OP_MUL  = 8'h03;
  localparam logic [OPC_W-1:0] OP_DIV  = 8'h04;
  localparam logic [OPC_W-1:0] OP_MOD  = 8'h05;
  localparam logic [OPC_W-1:0] OP_AND  = 8'h10;
  localparam logic [OPC_W-1:0] OP_OR   = 8'h11;
  localparam logic [OPC_W-1:0] OP_XOR  = 8'h12;
  localparam logic [OPC_W-1:0] OP_NOT  = 8'h13;
  localparam logic [OPC_W-1:0] OP_PUSH = 8'h22;
  localparam logic [OPC_W-1:0] OP_POP  = 8'h23;
  localparam logic [OPC_W-1:0] OP_DUP  = 8'h24;
  localparam logic [OPC_W-1:0] OP_SWAP = 8'h41;
  localparam logic [OPC_W-1:0] OP_NOP  = 8'h60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } err_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] need;
    logic       grow;
    logic       shrink;
  } op_info_t;

  function automatic op_info_t op_info(input logic [OPC_W-1:0] op);
    op_info_t info;
    info = '{legal: 1'b1, need: 2'd0, grow: 1'b0, shrink: 1'b0};
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        info.need   = 2'd2;
        info.shrink = 1'b1;
      end
`ifdef UXN_MULDIV_EN
      OP_MUL, OP_DIV, OP_MOD: begin
        info.need   = 2'd2;
        info.shrink = 1'b1;
      end
`endif
      OP_NOT:  info.need = 2'd1;
      OP_PUSH: info.grow = 1'b1;
      OP_DUP: begin
        info.need = 2'd1;
        info.grow = 1'b1;
      end
      OP_POP: begin
        info.need   = 2'd1;
        info.shrink = 1'b1;
      end
      OP_SWAP: info.need = 2'd2;
      OP_NOP:  info.need = 2'd0;
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/uxn_alu.sv
// Combinational ALU for the stack execute unit: result = a op b (NOT uses b only).
// Build option: UXN_MULDIV_EN adds MUL/DIV/MOD; without it no multiplier/divider exists.
module uxn_alu
  import uxn_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [OPC_W-1:0]  op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              divz_o
);

  always_comb begin
    result_o = '0;
    divz_o   = 1'b0;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~b_i;
`ifdef UXN_MULDIV_EN
      OP_MUL: result_o = a_i * b_i;
      OP_DIV: begin
        divz_o   = (b_i == '0);
        result_o = (b_i == '0) ? '0 : a_i / b_i;
      end
      OP_MOD: begin
        divz_o   = (b_i == '0);
        result_o = (b_i == '0) ? '0 : a_i % b_i;
      end
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/uxn_stack_alu.sv
// Four-cycle stack-machine execute unit (IDLE->DECODE->EXEC->WB) over an internal data stack.
// Build option: UXN_MULDIV_EN enables MUL/DIV/MOD in the decoder and ALU.
module uxn_stack_alu
  import uxn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int OP_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OP_W+DATA_W-1:0]     instr_i,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [DATA_W-1:0]          tos,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int AW  = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [SPW-1:0]      sp_q, sp_d;
  err_e                err_code_q;
  logic [OP_W+DATA_W-1:0] ir_q;
  logic [DATA_W-1:0]   a_q, b_q, res_q;
  logic                divz_q;
  err_e                fault_q, dec_fault, wb_code;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [OP_W-1:0]     opc;
  logic [OP_W+7:0]     opx;
  logic [OPC_W-1:0]    op8;
  logic [DATA_W-1:0]   imm;
  logic                hi_zero;
  op_info_t            info;
  logic [AW-1:0]       idx_0, idx_m1, idx_m2;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_divz;

  // Opcodes wider than 8 bits are legal only if the extra upper bits are zero.
  always_comb begin
    opc     = ir_q[OP_W+DATA_W-1:DATA_W];
    imm     = ir_q[DATA_W-1:0];
    op8     = OPC_W'(opc);
    opx     = {8'h00, opc};
    hi_zero = ((opx >> 8) == '0);
    info    = op_info(op8);
    idx_0   = AW'(sp_q);
    idx_m1  = AW'(sp_q - SPW'(1));
    idx_m2  = AW'(sp_q - SPW'(2));
  end

  always_comb begin
    dec_fault = ERR_NONE;
    if (!(info.legal && hi_zero)) begin
      dec_fault = ERR_ILLEGAL;
    end else if (sp_q < SPW'(info.need)) begin
      dec_fault = ERR_UNDERFLOW;
    end else if ((SPW+1)'(sp_q) + (SPW+1)'(info.grow) > (SPW+1)'(DEPTH)) begin
      dec_fault = ERR_OVERFLOW;
    end
  end

  // Divide-by-zero is only known after EXEC and ranks below every decode fault.
  always_comb begin
    wb_code = fault_q;
    if (fault_q == ERR_NONE && divz_q) begin
      wb_code = ERR_ILLEGAL;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sp_d = sp_q;
    if (state_q == WB && wb_code == ERR_NONE) begin
      sp_d = sp_q + SPW'(info.grow) - SPW'(info.shrink);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sp_q       <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      if (state_q == WB) begin
        err_code_q <= wb_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (instr_ready && instr_valid) begin
      ir_q <= instr_i;
    end
    if (state_q == DECODE) begin
      a_q     <= mem[idx_m2];
      b_q     <= mem[idx_m1];
      fault_q <= dec_fault;
    end
    if (state_q == EXEC) begin
      res_q  <= alu_res;
      divz_q <= alu_divz;
    end
  end

  // Stack contents survive reset; a reset edge during WB suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == WB && wb_code == ERR_NONE) begin
      case (op8)
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
        OP_AND, OP_OR, OP_XOR: mem[idx_m2] <= res_q;
        OP_NOT:  mem[idx_m1] <= res_q;
        OP_PUSH: mem[idx_0]  <= imm;
        OP_DUP:  mem[idx_0]  <= b_q;
        OP_SWAP: begin
          mem[idx_m2] <= b_q;
          mem[idx_m1] <= a_q;
        end
        default: ;
      endcase
    end
  end

  uxn_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op8),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res),
    .divz_o   (alu_divz)
  );

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WB);
  assign err         = (state_q == WB) && (wb_code != ERR_NONE);
  assign err_code    = (state_q == WB) ? wb_code : err_code_q;
  assign tos         = (sp_q == '0) ? '0 : mem[idx_m1];
  assign depth       = sp_q;

endmodule

// File: tb/tb_uxn_stack_alu.sv
// Scoreboard bench for uxn_stack_alu (DATA_W=16, DEPTH=4): directed cases then random ops vs a queue-based stack model.
// Expectations follow UXN_MULDIV_EN the same way the design build does.
module tb_uxn_stack_alu;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int OP_W   = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [OP_W+DATA_W-1:0]  instr_i = '0;
  logic                    instr_valid = 1'b0;
  logic                    instr_ready, done, err;
  logic [1:0]              err_code;
  logic [DATA_W-1:0]       tos;
  logic [2:0]              depth;

  uxn_stack_alu #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_i     (instr_i),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .tos         (tos),
    .depth       (depth)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        e;
    logic [1:0]  code;
    logic [15:0] tos;
    int unsigned depth;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        pend;
  bit          pend_v = 0;
  logic [15:0] mstk[$];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Reference: stack as a queue, faults checked in priority order.
  function automatic exp_t model_exec(input logic [7:0] op, input logic [15:0] imm);
    exp_t        x;
    int          n;
    int          need;
    int          grow;
    bit          legal;
    logic [1:0]  code;
    logic [15:0] a, b, r;
    n = mstk.size();
    need = 0; grow = 0; legal = 1; r = '0;
    case (op)
      8'h01, 8'h02, 8'h10, 8'h11, 8'h12: need = 2;
      8'h03, 8'h04, 8'h05: begin
`ifdef UXN_MULDIV_EN
        need = 2;
`else
        legal = 0;
`endif
      end
      8'h13, 8'h23: need = 1;
      8'h22: grow = 1;
      8'h24: begin need = 1; grow = 1; end
      8'h41: need = 2;
      8'h60: need = 0;
      default: legal = 0;
    endcase
    a = (n >= 2) ? mstk[n-2] : 16'h0;
    b = (n >= 1) ? mstk[n-1] : 16'h0;
    if (!legal) code = 2'd3;
    else if (n < need) code = 2'd1;
    else if (n + grow > DEPTH) code = 2'd2;
    else if ((op == 8'h04 || op == 8'h05) && b == 16'h0) code = 2'd3;
    else code = 2'd0;
    if (code == 2'd0) begin
      case (op)
        8'h01: r = a + b;
        8'h02: r = a - b;
        8'h03: r = 16'(a * b);
        8'h04: r = a / b;
        8'h05: r = a % b;
        8'h10: r = a & b;
        8'h11: r = a | b;
        8'h12: r = a ^ b;
        default: r = '0;
      endcase
      case (op)
        8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h12: begin
          void'(mstk.pop_back());
          void'(mstk.pop_back());
          mstk.push_back(r);
        end
        8'h13: mstk[n-1] = ~b;
        8'h22: mstk.push_back(imm);
        8'h24: mstk.push_back(b);
        8'h23: void'(mstk.pop_back());
        8'h41: begin mstk[n-2] = b; mstk[n-1] = a; end
        default: ;
      endcase
    end
    x.e     = (code != 2'd0);
    x.code  = code;
    x.depth = mstk.size();
    x.tos   = (mstk.size() > 0) ? mstk[mstk.size()-1] : 16'h0;
    x.due   = 0;
    return x;
  endfunction

  // Monitor: compare retire outputs on done, then tos/depth one cycle later.
  always @(negedge clk) begin
    if (pend_v) begin
      chk("tos_after_wb", tos, pend.tos);
      chk("depth_after_wb", depth, pend.depth);
      chk("err_code_held", err_code, pend.code);
      chk("done_single", done, 0);
      pend_v = 0;
    end
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no retire (t=%0t)", $time);
      end else begin
        pend = sbq.pop_front();
        chk("err", err, pend.e);
        chk("err_code", err_code, pend.code);
        chk("done_latency", cyc, pend.due);
        chk("ready_in_wb", instr_ready, 0);
        pend_v = 1;
      end
    end else if (sbq.size() > 0) begin
      chk("ready_busy", instr_ready, 0);
    end
  end

  task automatic wait_ready(output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = instr_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got instr_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] imm, input bit hold);
    exp_t x;
    bit   got;
    bit   drained;
    wait_ready(got);
    if (!got) return;
    instr_i     = {op, imm};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    x = model_exec(op, imm);
    x.due = cyc + 2;
    sbq.push_back(x);
    if (hold) begin
      repeat (3) begin
        @(posedge clk);
        #1;
      end
    end
    instr_valid = 1'b0;
    drained = 0;
    for (int i = 0; i < 12 && !drained; i++) begin
      @(negedge clk);
      #1;
      drained = (sbq.size() == 0) && !pend_v;
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: got no done for op 0x%0h expected done within 12 cycles", op);
      sbq.delete();
      pend_v = 0;
    end
  endtask

  task automatic clear_stack();
    int n;
    n = mstk.size();
    for (int i = 0; i < n; i++) issue(8'h23, 16'h0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_tos"}, tos, 0);
    chk({tag, "_depth"}, depth, 0);
  endtask

  logic [7:0] oplist [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11,
                              8'h12, 8'h13, 8'h22, 8'h23, 8'h24, 8'h41, 8'h60};

  initial begin
    bit          got;
    logic [7:0]  op;
    logic [15:0] imm;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Basic add, sub wrap, multiply truncation
    issue(8'h22, 16'h0003, 0);
    issue(8'h22, 16'h0005, 0);
    issue(8'h01, 16'h0000, 0);
    clear_stack();
    issue(8'h22, 16'h0002, 0);
    issue(8'h22, 16'h0005, 0);
    issue(8'h02, 16'h0000, 0);
    clear_stack();
    issue(8'h22, 16'h0100, 0);
    issue(8'h22, 16'h0100, 0);
    issue(8'h03, 16'h0000, 0);
    clear_stack();

    // Overflow at full stack, underflow at empty
    for (int i = 0; i < 4; i++) issue(8'h22, 16'(16'h1000 + i), 0);
    issue(8'h22, 16'h1234, 0);
    issue(8'h24, 16'h0000, 0);
    for (int i = 0; i < 4; i++) issue(8'h23, 16'h0, 0);
    issue(8'h23, 16'h0, 0);

    // Divide by zero, illegal opcode with valid held through the pipeline
    issue(8'h22, 16'h0007, 0);
    issue(8'h22, 16'h0000, 0);
    issue(8'h04, 16'h0000, 0);
    issue(8'h7F, 16'h0000, 1);
    issue(8'h41, 16'h0000, 1);
    clear_stack();

    // ADD and SWAP at SP=1 underflow
    issue(8'h22, 16'hBEEF, 0);
    issue(8'h01, 16'h0000, 0);
    issue(8'h41, 16'h0000, 0);

    // Reset while ADD is in EXEC
    issue(8'h22, 16'h0009, 0);
    wait_ready(got);
    if (got) begin
      instr_i     = {8'h01, 16'h0000};
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mstk.delete();
      @(posedge clk);
      @(negedge clk);
      check_reset_state("mid_reset");
      rst_n = 1'b1;
    end

    // Random phase
    for (int k = 0; k < 90; k++) begin
      if ($urandom_range(0, 9) == 0) op = 8'($urandom);
      else op = oplist[$urandom_range(0, 13)];
      if ($urandom_range(0, 3) == 0) imm = 16'($urandom_range(0, 2));
      else imm = 16'($urandom);
      issue(op, imm, ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
